vx_commit_wb: RTL and testbench
===============================

# vx_commit_wb

Commit-side collector for the execute stage: accepts the per-unit commit streams (alu, ld, csr, fpu, gpu, st) and retires them. Writeback commits are round-robin arbitrated into a single registered writeback port toward the register file. The block also reports the number of instructions retired per cycle to the CSR unit. It sits between the execute units' `VX_commit_if` outputs and the issue/register-file writeback path.

## Interface
- `NUM_THREADS`, 4, lanes per warp.
- `NUM_WARPS`, 4, warps per core; `NW_BITS = $clog2(NUM_WARPS)`, minimum 1.
- `CORE_ID`, 0, core index; used for debug only.
- Source index `i` is fixed as 0=alu, 1=ld, 2=csr, 3=fpu, 4=gpu. Vectors below are packed by `i`.
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous active-low reset; state clears on `clk` edge while `reset==0`.
- `commit_valid`, in, 5, per-source commit valid.
- `commit_ready`, out, 5, per-source accept.
- `commit_wid`, in, 5×NW_BITS, warp id.
- `commit_PC`, in, 5×32, instruction PC.
- `commit_tmask`, in, 5×NUM_THREADS, thread mask.
- `commit_wb`, in, 5, writeback request flag.
- `commit_rd`, in, 5×5, destination register.
- `commit_data`, in, 5×NUM_THREADS×32, result lanes.
- `st_commit_valid`, in, 1, store retire; carries no data.
- `st_commit_ready`, out, 1, tied to 1 while out of reset.
- `writeback_valid`, out, 1, registered writeback entry valid.
- `writeback_ready`, in, 1, register file accepts.
- `writeback_wid`, out, NW_BITS, warp id of the writeback.
- `writeback_PC`, out, 32, PC of the writeback.
- `writeback_tmask`, out, NUM_THREADS, thread mask of the writeback.
- `writeback_rd`, out, 5, destination register.
- `writeback_data`, out, NUM_THREADS×32, result lanes.
- `cmt_to_csr_valid`, out, 1, retire report valid.
- `cmt_to_csr_commit_size`, out, 3, instructions retired in the reported cycle (0..6).
- `busy`, out, 1, equals `writeback_valid`.

## Operation
- **Non-writeback commits** (`commit_valid[i] & !commit_wb[i]`):
  - `commit_ready[i]=1` in the same cycle, unconditionally.
  - Retired immediately; never enter arbitration.
- **Writeback requests**: `req[i] = commit_valid[i] & commit_wb[i]`.
- **Output register**: one entry. `load_en = !writeback_valid | writeback_ready`.
- **Arbitration**:
  - 3-bit pointer `rr_ptr` in 0..4.
  - Grant the first `i` with `req[i]` scanning `rr_ptr, rr_ptr+1, …` modulo 5 (4 wraps to 0).
  - At most one grant per cycle.
- **Handshake**:
  - `commit_ready[i]=grant[i] & load_en` for writeback requests.
  - On a fired grant: the entry loads `wid/PC/tmask/rd/data` of the winner, `writeback_valid<=1`, and `rr_ptr<=(grant+1) mod 5`.
- **Drain**: `writeback_valid & writeback_ready` with no new grant -> `writeback_valid<=0`. The payload holds its last value.
- **Stall**: while `writeback_valid & !writeback_ready`, the entry payload and `rr_ptr` are frozen.
- **tmask**: passed through unmodified. `tmask==0` with `wb=1` still produces a writeback entry.
- **Retire count**:
  - `n` = number of handshakes this cycle (non-wb accepts + fired grant + `st_commit_valid`).
  - Registered: `cmt_to_csr_valid<=(n!=0)`, `cmt_to_csr_commit_size<=n`.
  - One count per instruction, not per thread.
- **Reset** (`reset==0` at edge):
  - `writeback_valid`, `cmt_to_csr_valid`, `rr_ptr`, `cmt_to_csr_commit_size`, and all writeback payload outputs clear to 0.
  - `commit_ready` and `st_commit_ready` are 0 while reset is asserted.
  - An entry pending at reset is discarded; no writeback and no count.

## Timing
- Commit handshake at cycle T -> `writeback_valid` at T+1.
- Retire report for cycle T is presented at T+1.
- Throughput: one writeback per cycle while `writeback_ready` is held 1; non-wb retires are unlimited (up to 6 per cycle total).
- `commit_ready` depends combinationally on `commit_valid`, `commit_wb`, `writeback_valid`, `writeback_ready`, and `rr_ptr`. No combinational path runs from `commit_*` payload to any output.
- Simultaneous drain and load in the same cycle: the entry is replaced without a bubble.
- Sources must hold `commit_*` stable while `valid & !ready`. The block does not check this.

## Test plan
- **Reset values**: hold reset low for 3 cycles with all sources valid.
  - -> all `commit_ready=0`, `writeback_valid=0`, `cmt_to_csr_valid=0`.
  - After release, the first grant goes to alu (rr_ptr=0).
- **Round-robin**: all five sources hold `wb=1` continuously, `writeback_ready=1`.
  - -> grant order alu, ld, csr, fpu, gpu, alu, ….
  - `writeback_valid` is high every cycle from T+1, with `cmt_to_csr_commit_size=1` each cycle.
- **Backpressure**: ld commit `rd=7`, `data` lane0=`0xDEADBEEF`, `writeback_ready=0` for 4 cycles.
  - -> the entry holds `rd=7` and lane0=`0xDEADBEEF` stable, and all `commit_ready` for wb requests stay 0.
  - When `writeback_ready` rises, the next grant loads in the same cycle.
- **Mixed retire**: in one cycle, alu `wb=0`, csr `wb=0`, fpu `wb=1`, and store valid, with the output empty.
  - -> all accepted that cycle.
  - Next cycle: `cmt_to_csr_commit_size=4`, and the writeback carries fpu's `PC`.
- **Wrap-around**: only gpu (i=4) requests, then only alu.
  - -> after gpu's grant, `rr_ptr=0` and alu is granted next cycle with no idle cycle.
- **Reset mid-operation**: assert reset while `writeback_valid=1` and `writeback_ready=0`.
  - -> `writeback_valid=0` after the reset edge.
  - No writeback handshake or retire count is produced for the discarded entry.

Source files
------------

// File: rtl/vx_commit_wb.sv
// Commit-side collector: retires non-writeback commits immediately, round-robin
// arbitrates writeback commits into one registered writeback port, and reports retires per cycle.
module vx_commit_wb #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int CORE_ID     = 0,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4:0]                      commit_valid,
  output logic [4:0]                      commit_ready,
  input  logic [5*NW_BITS-1:0]            commit_wid,
  input  logic [5*32-1:0]                 commit_PC,
  input  logic [5*NUM_THREADS-1:0]        commit_tmask,
  input  logic [4:0]                      commit_wb,
  input  logic [5*5-1:0]                  commit_rd,
  input  logic [5*NUM_THREADS*32-1:0]     commit_data,
  input  logic                            st_commit_valid,
  output logic                            st_commit_ready,
  output logic                            writeback_valid,
  input  logic                            writeback_ready,
  output logic [NW_BITS-1:0]              writeback_wid,
  output logic [31:0]                     writeback_PC,
  output logic [NUM_THREADS-1:0]          writeback_tmask,
  output logic [4:0]                      writeback_rd,
  output logic [NUM_THREADS*32-1:0]       writeback_data,
  output logic                            cmt_to_csr_valid,
  output logic [2:0]                      cmt_to_csr_commit_size,
  output logic                            busy
);

  localparam int DW = NUM_THREADS * 32;

  logic [4:0] req;
  logic [4:0] nwb_accept;
  logic [4:0] grant;
  logic [2:0] rr_ptr;
  logic [2:0] rr_next;
  logic [2:0] grant_idx;
  logic [3:0] scan;
  logic       grant_found;
  logic       load_en;
  logic       fire;
  logic [2:0] retire_cnt;

  assign load_en    = !writeback_valid || writeback_ready;
  assign req        = commit_valid & commit_wb;
  assign nwb_accept = commit_valid & ~commit_wb & {5{reset}};

  // First requester found scanning upward from rr_ptr, wrapping 4 -> 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    scan        = 4'd0;
    for (int k = 0; k < 5; k++) begin
      scan = {1'b0, rr_ptr} + 4'(k);
      if (scan >= 4'd5) scan = scan - 4'd5;
      if (!grant_found && req[scan[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[2:0];
      end
    end
  end

  assign fire    = grant_found && load_en && reset;
  assign grant   = fire ? (5'b00001 << grant_idx) : 5'b00000;
  assign rr_next = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;

  assign commit_ready    = nwb_accept | grant;
  assign st_commit_ready = reset && (CORE_ID >= 0);
  assign busy            = writeback_valid;

  always_comb begin
    retire_cnt = {2'b00, fire} + {2'b00, st_commit_valid & reset};
    for (int i = 0; i < 5; i++) begin
      retire_cnt = retire_cnt + {2'b00, nwb_accept[i]};
    end
  end

  // Payload and rr_ptr only move on a fired grant, so a stalled entry stays frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      writeback_valid        <= 1'b0;
      writeback_wid          <= '0;
      writeback_PC           <= '0;
      writeback_tmask        <= '0;
      writeback_rd           <= '0;
      writeback_data         <= '0;
      rr_ptr                 <= 3'd0;
      cmt_to_csr_valid       <= 1'b0;
      cmt_to_csr_commit_size <= 3'd0;
    end else begin
      if (fire) begin
        writeback_valid <= 1'b1;
        writeback_wid   <= commit_wid[grant_idx*NW_BITS +: NW_BITS];
        writeback_PC    <= commit_PC[grant_idx*32 +: 32];
        writeback_tmask <= commit_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
        writeback_rd    <= commit_rd[grant_idx*5 +: 5];
        writeback_data  <= commit_data[grant_idx*DW +: DW];
        rr_ptr          <= rr_next;
      end else if (writeback_ready) begin
        writeback_valid <= 1'b0;
      end
      cmt_to_csr_valid       <= (retire_cnt != 3'd0);
      cmt_to_csr_commit_size <= retire_cnt;
    end
  end

endmodule

// File: tb/tb_vx_commit_wb.sv
// Directed bench for vx_commit_wb: expected writebacks go into a scoreboard queue when
// the granting stimulus is driven and are popped by a monitor on each writeback handshake.
module tb_vx_commit_wb;

  localparam int NT  = 4;
  localparam int NWB = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [4:0]           commit_valid;
  logic [4:0]           commit_ready;
  logic [5*NWB-1:0]     commit_wid;
  logic [5*32-1:0]      commit_PC;
  logic [5*NT-1:0]      commit_tmask;
  logic [4:0]           commit_wb;
  logic [5*5-1:0]       commit_rd;
  logic [5*NT*32-1:0]   commit_data;
  logic                 st_commit_valid;
  logic                 st_commit_ready;
  logic                 writeback_valid;
  logic                 writeback_ready;
  logic [NWB-1:0]       writeback_wid;
  logic [31:0]          writeback_PC;
  logic [NT-1:0]        writeback_tmask;
  logic [4:0]           writeback_rd;
  logic [NT*32-1:0]     writeback_data;
  logic                 cmt_to_csr_valid;
  logic [2:0]           cmt_to_csr_commit_size;
  logic                 busy;

  typedef struct {
    logic [NWB-1:0]   wid;
    logic [31:0]      pc;
    logic [NT-1:0]    tmask;
    logic [4:0]       rd;
    logic [NT*32-1:0] data;
  } wb_entry_t;

  wb_entry_t exp_q[$];
  wb_entry_t src_entry[5];
  wb_entry_t mon_entry;
  int        check_count = 0;
  int        fail_count  = 0;

  always #5 clk = ~clk;

  vx_commit_wb #(.NUM_THREADS(NT), .NUM_WARPS(4), .CORE_ID(0)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .commit_valid           (commit_valid),
    .commit_ready           (commit_ready),
    .commit_wid             (commit_wid),
    .commit_PC              (commit_PC),
    .commit_tmask           (commit_tmask),
    .commit_wb              (commit_wb),
    .commit_rd              (commit_rd),
    .commit_data            (commit_data),
    .st_commit_valid        (st_commit_valid),
    .st_commit_ready        (st_commit_ready),
    .writeback_valid        (writeback_valid),
    .writeback_ready        (writeback_ready),
    .writeback_wid          (writeback_wid),
    .writeback_PC           (writeback_PC),
    .writeback_tmask        (writeback_tmask),
    .writeback_rd           (writeback_rd),
    .writeback_data         (writeback_data),
    .cmt_to_csr_valid       (cmt_to_csr_valid),
    .cmt_to_csr_commit_size (cmt_to_csr_commit_size),
    .busy                   (busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic wb, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [31:0] lane0, input logic [NT-1:0] tmask);
    logic [NT*32-1:0] data;
    data = {lane0 + 32'd3, lane0 + 32'd2, lane0 + 32'd1, lane0};
    commit_valid[i]            = 1'b1;
    commit_wb[i]               = wb;
    commit_wid[i*NWB +: NWB]   = NWB'(i);
    commit_PC[i*32 +: 32]      = pc;
    commit_tmask[i*NT +: NT]   = tmask;
    commit_rd[i*5 +: 5]        = rd;
    commit_data[i*NT*32 +: NT*32] = data;
    src_entry[i] = '{wid: NWB'(i), pc: pc, tmask: tmask, rd: rd, data: data};
  endtask

  task automatic clearSources();
    commit_valid = 5'b0;
    commit_wb    = 5'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every writeback handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && writeback_valid === 1'b1 && writeback_ready === 1'b1) begin
      checkOutput("wb_expected_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        mon_entry = exp_q.pop_front();
        checkOutput("wb_wid", 128'(writeback_wid), 128'(mon_entry.wid));
        checkOutput("wb_pc", 128'(writeback_PC), 128'(mon_entry.pc));
        checkOutput("wb_tmask", 128'(writeback_tmask), 128'(mon_entry.tmask));
        checkOutput("wb_rd", 128'(writeback_rd), 128'(mon_entry.rd));
        checkOutput("wb_data", 128'(writeback_data), 128'(mon_entry.data));
      end
    end
  end

  initial begin
    reset = 1'b0;
    commit_valid = '0; commit_wb = '0; commit_wid = '0; commit_PC = '0;
    commit_tmask = '0; commit_rd = '0; commit_data = '0;
    st_commit_valid = 1'b0;
    writeback_ready = 1'b1;

    // Reset held with every source requesting.
    for (int i = 0; i < 5; i++)
      applyStimulus(i, 1'b1, 32'h1000 + 32'(i * 16), 5'(i + 1), 32'hA000_0000 + 32'(i), 4'b1111);
    st_commit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("reset_commit_ready", 128'(commit_ready), 128'd0);
      checkOutput("reset_st_ready", 128'(st_commit_ready), 128'd0);
      checkOutput("reset_wb_valid", 128'(writeback_valid), 128'd0);
      checkOutput("reset_cmt_valid", 128'(cmt_to_csr_valid), 128'd0);
    end

    // Round-robin with all five sources requesting continuously.
    nextCycle();
    reset = 1'b1;
    st_commit_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", 128'(commit_ready), 128'(5'b00001 << (k % 5)));
      exp_q.push_back(src_entry[k % 5]);
      if (k > 0) begin
        checkOutput("rr_wb_valid", 128'(writeback_valid), 128'd1);
        checkOutput("rr_busy", 128'(busy), 128'd1);
        checkOutput("rr_cmt_valid", 128'(cmt_to_csr_valid), 128'd1);
        checkOutput("rr_cmt_size", 128'(cmt_to_csr_commit_size), 128'd1);
      end
      nextCycle();
    end
    clearSources();
    @(negedge clk);
    checkOutput("rr_last_valid", 128'(writeback_valid), 128'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("drain_wb_valid", 128'(writeback_valid), 128'd0);
    checkOutput("drain_cmt_valid", 128'(cmt_to_csr_valid), 128'd0);

    // Backpressure: ld entry held while the register file stalls.
    nextCycle();
    writeback_ready = 1'b0;
    applyStimulus(1, 1'b1, 32'h2000, 5'd7, 32'hDEAD_BEEF, 4'b0101);
    @(negedge clk);
    checkOutput("bp_ld_grant", 128'(commit_ready), 128'(5'b00010));
    exp_q.push_back(src_entry[1]);
    nextCycle();
    clearSources();
    applyStimulus(0, 1'b1, 32'h3000, 5'd3, 32'h3000_0000, 4'b1111);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checkOutput("bp_wb_valid", 128'(writeback_valid), 128'd1);
      checkOutput("bp_rd", 128'(writeback_rd), 128'd7);
      checkOutput("bp_lane0", 128'(writeback_data[31:0]), 128'h0DEAD_BEEF);
      checkOutput("bp_ready_blocked", 128'(commit_ready), 128'd0);
      nextCycle();
    end
    writeback_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant", 128'(commit_ready), 128'(5'b00001));
    exp_q.push_back(src_entry[0]);
    nextCycle();
    clearSources();
    @(negedge clk);
    checkOutput("bp_replace_valid", 128'(writeback_valid), 128'd1);
    checkOutput("bp_replace_pc", 128'(writeback_PC), 128'h3000);
    checkOutput("bp_cmt_size", 128'(cmt_to_csr_commit_size), 128'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_empty", 128'(writeback_valid), 128'd0);

    // Mixed retire: two non-wb, one wb and a store in the same cycle.
    nextCycle();
    applyStimulus(0, 1'b0, 32'h5000, 5'd1, 32'h5000_0000, 4'b1111);
    applyStimulus(2, 1'b0, 32'h5200, 5'd2, 32'h5200_0000, 4'b1111);
    applyStimulus(3, 1'b1, 32'h4000, 5'd9, 32'h4444_0000, 4'b0011);
    st_commit_valid = 1'b1;
    @(negedge clk);
    checkOutput("mix_ready", 128'(commit_ready), 128'(5'b01101));
    checkOutput("mix_st_ready", 128'(st_commit_ready), 128'd1);
    exp_q.push_back(src_entry[3]);
    nextCycle();
    clearSources();
    st_commit_valid = 1'b0;
    @(negedge clk);
    checkOutput("mix_cmt_valid", 128'(cmt_to_csr_valid), 128'd1);
    checkOutput("mix_cmt_size", 128'(cmt_to_csr_commit_size), 128'd4);
    checkOutput("mix_wb_pc", 128'(writeback_PC), 128'h4000);

    // Wrap-around: gpu, then alu and ld; tmask of zero still writes back.
    nextCycle();
    applyStimulus(4, 1'b1, 32'h6000, 5'd12, 32'h6000_0000, 4'b0000);
    @(negedge clk);
    checkOutput("wrap_gpu_grant", 128'(commit_ready), 128'(5'b10000));
    exp_q.push_back(src_entry[4]);
    nextCycle();
    clearSources();
    applyStimulus(0, 1'b1, 32'h7000, 5'd13, 32'h7000_0000, 4'b1000);
    applyStimulus(1, 1'b1, 32'h7100, 5'd14, 32'h7100_0000, 4'b0110);
    @(negedge clk);
    checkOutput("wrap_alu_grant", 128'(commit_ready), 128'(5'b00001));
    checkOutput("wrap_tmask_zero_valid", 128'(writeback_valid), 128'd1);
    checkOutput("wrap_tmask_zero", 128'(writeback_tmask), 128'd0);
    exp_q.push_back(src_entry[0]);
    nextCycle();
    commit_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("wrap_ld_grant", 128'(commit_ready), 128'(5'b00010));
    checkOutput("wrap_alu_pc", 128'(writeback_PC), 128'h7000);
    exp_q.push_back(src_entry[1]);
    nextCycle();
    clearSources();
    @(negedge clk);
    checkOutput("wrap_ld_pc", 128'(writeback_PC), 128'h7100);
    nextCycle();

    // Reset while an entry is stalled: it must vanish without a writeback.
    writeback_ready = 1'b0;
    applyStimulus(2, 1'b1, 32'h8000, 5'd20, 32'h8000_0000, 4'b1111);
    @(negedge clk);
    checkOutput("rst_mid_grant", 128'(commit_ready), 128'(5'b00100));
    nextCycle();
    clearSources();
    @(negedge clk);
    checkOutput("rst_mid_pending", 128'(writeback_valid), 128'd1);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_st_ready", 128'(st_commit_ready), 128'd0);
    nextCycle();
    reset = 1'b1;
    writeback_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_wb_valid", 128'(writeback_valid), 128'd0);
    checkOutput("rst_mid_cmt_valid", 128'(cmt_to_csr_valid), 128'd0);
    checkOutput("rst_mid_rd", 128'(writeback_rd), 128'd0);
    checkOutput("rst_mid_pc", 128'(writeback_PC), 128'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_mid_still_idle", 128'(writeback_valid), 128'd0);
    checkOutput("rst_mid_no_count", 128'(cmt_to_csr_valid), 128'd0);

    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
